subcounter_sched: RTL and testbench

//  Sequences a bank of num_sub chained subcounters as one shared wide counter of num_sub*granularity bits.

---
 rtl/subcounter_sched_pkg.sv | 19 +
 rtl/subcounter_sched_rr_arbiter.sv | 34 +++
 rtl/subcounter_sched.sv | 125 ++++++++++++
 tb/tb_subcounter_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subcounter_sched_pkg.sv
// Shared encodings for the subcounter scheduler: subcounter commands, request ops and FSM states.
package subcounter_pkg;

  localparam logic [1:0] CMD_CLR  = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_HOLD = 2'b10;

  localparam logic [1:0] OP_CLEAR    = 2'b00;
  localparam logic [1:0] OP_INC      = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [1:0] OP_READ_ALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    ACK   = 2'b10
  } state_t;

endpackage

// File: rtl/subcounter_sched_rr_arbiter.sv
// Round-robin arbiter: first active request at or after the pointer, wrapping, as one-hot and index.
module rr_arbiter #(
  parameter int num_req = 4,
  parameter int IDXW    = $clog2(num_req)
) (
  input  logic [num_req-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  output logic [num_req-1:0] o_grant,
  output logic [IDXW-1:0]    o_idx,
  output logic               o_valid
);

  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(num_req);

  logic [IDXW:0] w_sum;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < num_req; i++) begin
      w_sum = {1'b0, i_ptr} + (IDXW+1)'(i);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!o_valid && i_req[w_sum[IDXW-1:0]]) begin
        o_valid                  = 1'b1;
        o_idx                    = w_sum[IDXW-1:0];
        o_grant[w_sum[IDXW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/subcounter_sched.sv
// Schedules round-robin clear/increment/read ops onto a chained subcounter bank used as one wide counter.
// Define SUBCOUNTER_SCHED_SATURATE_EN to hold the bank at all-ones on overflow instead of wrapping to 0.
module subcounter_sched
  import subcounter_pkg::*;
#(
  parameter int granularity = 4,
  parameter int num_sub     = 4,
  parameter int num_req     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [num_req-1:0]               req_valid,
  input  logic [2*num_req-1:0]             req_cmd,
  output logic [num_req-1:0]               ack,
  output logic [num_sub*granularity-1:0]   rsp_data,
  output logic                             rsp_ovf,
  output logic [2*num_sub-1:0]             sub_command_out,
  input  logic [num_sub*granularity-1:0]   sub_data_in
);

  localparam int IDXW = $clog2(num_req);

  state_t               r_state;
  state_t               w_next;
  logic [IDXW-1:0]      r_ptr;
  logic [IDXW-1:0]      r_gidx;
  logic [num_req-1:0]   r_grant;
  logic [1:0]           r_op;
  logic                 r_ovf;

  logic [num_req-1:0]   w_grant;
  logic [IDXW-1:0]      w_gidx;
  logic                 w_gvalid;
  logic [num_sub-1:0]   w_carry;
  logic                 w_all_ones;

  rr_arbiter #(
    .num_req (num_req),
    .IDXW    (IDXW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  // Carry lookahead: sub k may increment only when every lower sub is all-ones.
  always_comb begin
    logic w_acc;
    w_acc   = 1'b1;
    w_carry = '0;
    for (int k = 0; k < num_sub; k++) begin
      w_carry[k] = w_acc;
      w_acc      = w_acc & (&sub_data_in[k*granularity +: granularity]);
    end
    w_all_ones = w_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_op    <= OP_READ;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_gvalid) begin
            r_gidx  <= w_gidx;
            r_grant <= w_grant;
            r_op    <= req_cmd[{w_gidx, 1'b0} +: 2];
          end
        end
        ISSUE: r_ovf <= (r_op == OP_INC) && w_all_ones;
        ACK: begin
          if (r_gidx == IDXW'(num_req - 1)) r_ptr <= '0;
          else                              r_ptr <= r_gidx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gvalid) w_next = ISSUE;
      ISSUE:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset overrides everything so the bank clears while rst is held, even mid-op.
  always_comb begin
    sub_command_out = {num_sub{CMD_HOLD}};
    ack             = '0;
    rsp_data        = '0;
    rsp_ovf         = 1'b0;
    if (rst) begin
      sub_command_out = {num_sub{CMD_CLR}};
    end else if (r_state == ISSUE) begin
      case (r_op)
        OP_CLEAR: sub_command_out = {num_sub{CMD_CLR}};
        OP_INC: begin
          for (int k = 0; k < num_sub; k++)
            sub_command_out[2*k +: 2] = w_carry[k] ? CMD_INC : CMD_HOLD;
`ifdef SUBCOUNTER_SCHED_SATURATE_EN
          if (w_all_ones) sub_command_out = {num_sub{CMD_HOLD}};
`endif
        end
        default: sub_command_out = {num_sub{CMD_HOLD}};
      endcase
    end else if (r_state == ACK) begin
      ack      = r_grant;
      rsp_data = sub_data_in;
      rsp_ovf  = r_ovf;
    end
  end

endmodule

// File: tb/tb_subcounter_sched.sv
// Directed bench for subcounter_sched with a behavioural subcounter bank and an ack scoreboard.
module tb_subcounter_sched;

  localparam int GR = 4;
  localparam int NS = 4;
  localparam int NR = 4;
  localparam int W  = GR * NS;

  typedef struct {
    int             idx;
    logic [W-1:0]   data;
    logic           ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [2*NR-1:0]   req_cmd = '0;
  logic [NR-1:0]     ack;
  logic [W-1:0]      rsp_data;
  logic              rsp_ovf;
  logic [2*NS-1:0]   sub_command_out;
  logic [W-1:0]      sub_data_in;

  logic [W-1:0]      bankQ;
  logic              preEn = 1'b0;
  logic [W-1:0]      preVal = '0;

  exp_t              sbq[$];
  logic [W-1:0]      expVal = '0;
  int                nCompared = 0;
  int                nMismatched = 0;
  int                cyc = 0;
  int                sub1Inc = 0;
  int                lastLatency = 0;

  subcounter_sched #(
    .granularity (GR),
    .num_sub     (NS),
    .num_req     (NR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_cmd         (req_cmd),
    .ack             (ack),
    .rsp_data        (rsp_data),
    .rsp_ovf         (rsp_ovf),
    .sub_command_out (sub_command_out),
    .sub_data_in     (sub_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural subcounter bank: 00 clear, 01 increment, otherwise hold; preload is bench-only.
  always @(posedge clk) begin
    if (preEn) bankQ <= preVal;
    else begin
      for (int k = 0; k < NS; k++) begin
        case (sub_command_out[2*k +: 2])
          2'b00:   bankQ[k*GR +: GR] <= '0;
          2'b01:   bankQ[k*GR +: GR] <= bankQ[k*GR +: GR] + 4'd1;
          default: ;
        endcase
      end
    end
  end
  assign sub_data_in = bankQ;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && sub_command_out[3:2] == 2'b01) sub1Inc++;
    if (!rst && ack != '0) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("ack_onehot", 32'(ack), 32'(1) << e.idx);
        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
        checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      end
    end
  end

  function automatic exp_t predict(input int idx, input logic [1:0] cmd);
    exp_t e;
    e.idx = idx;
    case (cmd)
      2'b00: begin e.data = '0; e.ovf = 1'b0; end
      2'b01: begin
        e.ovf = (expVal == 16'hFFFF);
`ifdef SUBCOUNTER_SCHED_SATURATE_EN
        e.data = e.ovf ? 16'hFFFF : expVal + 16'd1;
`else
        e.data = expVal + 16'd1;
`endif
      end
      default: begin e.data = expVal; e.ovf = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic pushExp(input int idx, input logic [1:0] cmd);
    exp_t e;
    e = predict(idx, cmd);
    expVal = e.data;
    sbq.push_back(e);
  endtask

  // Single requester op: raise, wait for its ack, drop.
  task automatic applyStimulus(input int idx, input logic [1:0] cmd);
    int waits;
    pushExp(idx, cmd);
    @(posedge clk); #1;
    req_valid[idx] = 1'b1;
    req_cmd[2*idx +: 2] = cmd;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!ack[idx] && waits < 12);
    lastLatency = waits;
    if (!ack[idx]) begin
      checkOutput("ack_timeout", 32'(ack[idx]), 32'd1);
      sbq.delete();
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic waitAcks(input int n);
    int got;
    int waits;
    logic [NR-1:0] seen;
    got = 0;
    waits = 0;
    while (got < n && waits < 30) begin
      @(negedge clk);
      waits++;
      if (ack != '0) begin
        got++;
        seen = ack;
        @(posedge clk); #1;
        req_valid = req_valid & ~seen;
      end
    end
    if (got < n) begin
      checkOutput("ack_timeout_multi", 32'(got), 32'(n));
      sbq.delete();
    end
  endtask

  task automatic resetDut(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("reset_cmd", 32'(sub_command_out), 32'd0);
      checkOutput("reset_ack", 32'(ack), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    expVal = '0;
  endtask

  task automatic preload(input logic [W-1:0] v);
    @(posedge clk); #1;
    preEn = 1'b1;
    preVal = v;
    @(posedge clk); #1;
    preEn = 1'b0;
    expVal = v;
  endtask

  initial begin
    int prevCyc;
    int waits;

    // Test 1: reset clears the bank, idle holds, read returns 0 with two-cycle latency
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_cmd", 32'(sub_command_out), 32'd0);
      checkOutput("reset_rsp", 32'(rsp_data), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_hold", 32'(sub_command_out), 32'hAA);
    applyStimulus(0, 2'b10);
    checkOutput("read_latency", 32'(lastLatency), 32'd3);

    // Test 2: twenty increments from requester 0
    sub1Inc = 0;
    for (int i = 0; i < 20; i++) applyStimulus(0, 2'b01);
    applyStimulus(0, 2'b10);
    checkOutput("final_value", 32'(bankQ), 32'h0014);
    checkOutput("sub1_inc_count", 32'(sub1Inc), 32'd1);

    // Test 3: overflow from all-ones
    preload(16'hFFFF);
    applyStimulus(1, 2'b01);

    // Test 4: all requesters hold increments from reset
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '1;
    req_cmd = 8'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expVal = '0;
    pushExp(0, 2'b01);
    pushExp(1, 2'b01);
    pushExp(2, 2'b01);
    pushExp(3, 2'b01);
    pushExp(0, 2'b01);
    rst = 1'b0;
    prevCyc = 0;
    for (int n = 0; n < 5; n++) begin
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
      end while (ack == '0 && waits < 12);
      checkOutput("rr_ack_seen", 32'(ack != '0), 32'd1);
      if (n > 0) checkOutput("rr_ack_spacing", 32'(cyc - prevCyc), 32'd3);
      prevCyc = cyc;
      if (n == 4) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
    end
    repeat (4) @(negedge clk);
    if (sbq.size() != 0) sbq.delete();

    // Test 5: clear from r2 races a read from r1 at 0x0123
    resetDut(2);
    preload(16'h0123);
    pushExp(1, 2'b10);
    pushExp(2, 2'b00);
    @(posedge clk); #1;
    req_cmd = 8'b00_00_10_00 | 8'b00_00_00_00;
    req_cmd[3:2] = 2'b10;
    req_cmd[5:4] = 2'b00;
    req_valid = 4'b0110;
    waitAcks(2);
    checkOutput("bank_after_clear", 32'(bankQ), 32'd0);

    // Test 6: reset during ISSUE aborts the op and rewinds the pointer
    applyStimulus(1, 2'b01);
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    req_cmd[5:4] = 2'b01;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    expVal = '0;
    repeat (4) @(negedge clk);
    checkOutput("bank_after_abort", 32'(bankQ), 32'd0);
    pushExp(0, 2'b10);
    pushExp(3, 2'b10);
    @(posedge clk); #1;
    req_cmd[1:0] = 2'b10;
    req_cmd[7:6] = 2'b11;
    req_valid = 4'b1001;
    waitAcks(2);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
